// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built around one full_adder cell, LSB first

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic SUM,
    output logic CARRY
);
    assign SUM   = A ^ B ^ Cin;
    assign CARRY = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fa_sum, fa_carry;

    full_adder u_fa (
        .A     (a_q[0]),
        .B     (b_q[0]),
        .Cin   (carry_q),
        .SUM   (fa_sum),
        .CARRY (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, FIN: begin
                // FIN accepts a new request exactly like IDLE, giving back-to-back issue
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY = (state_q == SHIFT);
    assign DONE = (state_q == FIN);
    assign SUM  = sum_q;
    assign COUT = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder against an arithmetic model

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int tests = 0;
    int fails = 0;
    logic [7:0] last_sum8 = 8'h00;
    logic       last_cout8 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
        .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .A(a2), .B(b2), .CIN(cin2),
        .BUSY(busy2), .DONE(done2), .SUM(sum2), .COUT(cout2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // inject > 0 pulses START with junk operands during that busy cycle
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int inject);
        logic [8:0] ref_v;
        ref_v = {1'b0, a} + {1'b0, b} + {8'b0, c};
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk("op8_busy", 32'(busy8), 32'd1);
            chk("op8_done_low", 32'(done8), 32'd0);
            chk("op8_sum_hold", 32'(sum8), 32'(last_sum8));
            chk("op8_cout_hold", 32'(cout8), 32'(last_cout8));
            if (inject != 0 && i == inject) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            tick();
        end
        start8 = 1'b0;
        chk("op8_done", 32'(done8), 32'd1);
        chk("op8_busy_fin", 32'(busy8), 32'd0);
        chk("op8_sum", 32'(sum8), 32'(ref_v[7:0]));
        chk("op8_cout", 32'(cout8), 32'(ref_v[8]));
        last_sum8  = ref_v[7:0];
        last_cout8 = ref_v[8];
        tick();
        chk("op8_done_once", 32'(done8), 32'd0);
        chk("op8_idle", 32'(busy8), 32'd0);
        chk("op8_sum_keep", 32'(sum8), 32'(last_sum8));
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
        logic [2:0] ref_v;
        ref_v = {1'b0, a} + {1'b0, b} + {2'b0, c};
        start2 = 1'b1; a2 = a; b2 = b; cin2 = c;
        tick();
        start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            chk("op2_busy", 32'(busy2), 32'd1);
            chk("op2_done_low", 32'(done2), 32'd0);
            tick();
        end
        chk("op2_done", 32'(done2), 32'd1);
        chk("op2_result", 32'({cout2, sum2}), 32'(ref_v));
        tick();
        chk("op2_done_once", 32'(done2), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_w2", 32'({busy2, done2, cout2, sum2}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'hA5, 8'h5A, 1'b1, 0);
        op8(8'h7F, 8'h01, 1'b0, 0);
        op8(8'h12, 8'h34, 1'b0, 3);
        for (int n = 0; n < 20; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, 1'($urandom), 0);
        end

        // back-to-back with START held: DONE every 9 cycles, BUSY otherwise
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        tick();
        for (int c = 0; c < 27; c++) begin
            chk("b2b_done", 32'(done8), 32'((c % 9) == 8));
            chk("b2b_busy", 32'(busy8), 32'((c % 9) != 8));
            if ((c % 9) == 8) begin
                chk("b2b_sum", 32'(sum8), 32'h02);
                chk("b2b_cout", 32'(cout8), 32'd0);
            end
            tick();
        end
        start8 = 1'b0;
        repeat (10) tick();
        last_sum8 = 8'h02; last_cout8 = 1'b0;

        // asynchronous reset in the middle of an operation
        start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_sum", 32'(sum8), 32'd0);
        chk("arst_cout", 32'(cout8), 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_done", 32'(done8), 32'd0);
            chk("post_rst_busy", 32'(busy8), 32'd0);
        end
        last_sum8 = 8'h00; last_cout8 = 1'b0;
        op8(8'h03, 8'h04, 1'b0, 0);

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    op2(2'(a), 2'(b), 1'(c));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It accepts two WIDTH-bit operands plus carry-in, then produces one sum bit per clock, LSB first.
- Each bit is computed by a single instance of the existing full_adder cell (ports A, B, Cin, SUM, CARRY), with a registered carry between bits.
- Area-minimal alternative to a ripple array. Sits between an operand source and any result consumer, using a START/BUSY/DONE handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal values are 2 or greater.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request pulse; sampled only while BUSY=0.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- CIN  input  1  carry-in; sampled on the accepting edge.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse: SUM/COUT just updated.
- SUM  output  WIDTH  registered result, A+B+CIN mod 2^WIDTH.
- COUT  output  1  registered carry-out, bit WIDTH of A+B+CIN.

Behaviour:
- Reset: any cycle RST_N=0 asynchronously forces the following. Any in-flight operation is discarded. No DONE pulse follows release.
  - state=IDLE
  - BUSY=0, DONE=0, SUM=0, COUT=0
  - operand shift registers, carry register and bit counter all cleared
- States: IDLE, SHIFT, FIN.
- IDLE: BUSY=0, DONE=0. If START=1 at edge k, the edge does all of the following:
  - load A, B into shift registers
  - carry reg <= CIN, bit counter <= 0, state <= SHIFT, BUSY <= 1
- SHIFT: full_adder inputs are the shift-register LSBs and the carry reg. Each edge does all of the following:
  - shift the full_adder SUM into the MSB of the internal accumulator; shift the operand registers right by one
  - carry reg <= full_adder CARRY, counter += 1
- SHIFT exit: on the edge where counter==WIDTH-1 (edge k+WIDTH), do all of the following:
  - SUM <= final accumulator value, including this edge's bit
  - COUT <= this edge's CARRY
  - state <= FIN, BUSY <= 0, DONE <= 1
- FIN: DONE=1 for exactly one cycle.
  - Next edge with START=0: state <= IDLE, DONE <= 0.
  - Next edge with START=1: accepted exactly as in IDLE (back-to-back operation); DONE <= 0, BUSY <= 1.
- Latency: START accepted at edge k, so BUSY is high for WIDTH cycles, and DONE and the new SUM/COUT are visible after edge k+WIDTH. Minimum issue interval is WIDTH+1 cycles.
- START while BUSY=1 is ignored: no restart, no queueing, operands not resampled.
- A/B/CIN may change freely after the accepting edge.
- SUM/COUT change only on the completion edge (and on reset); they hold the last result through IDLE and through the next operation's SHIFT phase.
- Counter width is $clog2(WIDTH); wrap-around is never used, because the exit decode happens at WIDTH-1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8; A=0xFF, B=0x01, CIN=0, START pulsed one cycle -> after the accepting edge, BUSY is high for exactly 8 cycles, then DONE pulses high for 1 cycle with SUM=0x00, COUT=1. The full carry chain propagates.
- A=0xA5, B=0x5A, CIN=1 -> SUM=0x00, COUT=1. Then A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0. Between operations SUM holds 0x00 until the second completion edge.
- Start 0x12+0x34 (CIN=0); 3 cycles later pulse START with A=0xFF, B=0xFF -> second request ignored. Result is SUM=0x46, COUT=0, a single DONE, and BUSY unaffected.
- Back-to-back: hold START=1 continuously with 0x01+0x01, CIN=0.
  - First result is SUM=0x02, COUT=0.
  - The next operation is accepted on the cycle DONE is high; DONE period is 9 cycles.
- Reset mid-op: start 0xF0+0x0F, assert RST_N=0 asynchronously (between clock edges) after 4 cycles -> BUSY, DONE, SUM, COUT go 0 immediately. After release there is no DONE without a new START.
  - A fresh 0x03+0x04 then yields SUM=0x07.
- WIDTH=2: exhaustive check of all 32 combinations of A, B, CIN against the reference {COUT,SUM}=A+B+CIN. Each result is checked on the DONE cycle.
